write_pointer_full_flags: RTL

Write-domain pointer and flag generator for the async FIFO. It is the next generation of the basic write-pointer/full block, parametrised in depth and almost-full threshold. It adds a registered fill level, an almost-full flag, an accept strobe and a sticky overflow error. It sits in the write clock domain, drives the FIFO memory write address, and exports a Gray write pointer to the read-side synchroniser. It consumes the read pointer, already synchronised into write_clk and still Gray-coded.

---
 rtl/write_pointer_full_flags_if.sv | 42 ++++
 rtl/write_pointer_full_flags.sv | 71 +++++++
 2 files changed

// File: rtl/write_pointer_full_flags_if.sv
// Write-side FIFO pointer bus: the request/clear/read-pointer inputs and the
// pointer, address, level and flag outputs of write_pointer_full_flags.
interface write_pointer_full_flags_if #(
    parameter int address_size = 4
);
    logic                    write_increment;
    logic [address_size:0]   write_to_read_pointer;
    logic                    write_overflow_clear;
    logic                    write_accept;
    logic [address_size-1:0] write_address;
    logic [address_size:0]   write_pointer;
    logic                    write_full;
    logic                    write_almost_full;
    logic [address_size:0]   write_level;
    logic                    write_overflow;

    modport master (
        output write_increment,
        output write_to_read_pointer,
        output write_overflow_clear,
        input  write_accept,
        input  write_address,
        input  write_pointer,
        input  write_full,
        input  write_almost_full,
        input  write_level,
        input  write_overflow
    );

    modport slave (
        input  write_increment,
        input  write_to_read_pointer,
        input  write_overflow_clear,
        output write_accept,
        output write_address,
        output write_pointer,
        output write_full,
        output write_almost_full,
        output write_level,
        output write_overflow
    );
endinterface

// File: rtl/write_pointer_full_flags.sv
// Write-domain pointer, fill level and full/almost-full/overflow flags for an
// async FIFO; consumes the Gray read pointer already synchronised into write_clk.
module write_pointer_full_flags #(
    parameter int address_size          = 4,
    parameter int almost_full_threshold = 14
) (
    input logic                         write_clk,
    input logic                         write_reset,
    write_pointer_full_flags_if.slave   bus
);
    localparam logic [address_size:0] almost_full_level = (address_size + 1)'(almost_full_threshold);

    logic [address_size:0] bin;
    logic [address_size:0] bin_next;
    logic [address_size:0] gray_next;
    logic [address_size:0] gray_reg;
    logic [address_size:0] rbin;
    logic [address_size:0] level_next;
    logic [address_size:0] level_reg;
    logic [address_size:0] full_match;
    logic                  accept;
    logic                  full_reg;
    logic                  almost_full_reg;
    logic                  overflow_reg;

    // Full when the next write pointer sits exactly one lap ahead of the read
    // pointer; in Gray code that means the top two bits differ and the rest match.
    always_comb begin
        accept     = bus.write_increment & ~full_reg;
        bin_next   = bin + {{address_size{1'b0}}, accept};
        gray_next  = (bin_next >> 1) ^ bin_next;
        rbin       = '0;
        for (int i = 0; i <= address_size; i++) begin
            rbin[i] = ^(bus.write_to_read_pointer >> i);
        end
        level_next = bin_next - rbin;
        full_match = {~bus.write_to_read_pointer[address_size:address_size-1],
                      bus.write_to_read_pointer[address_size-2:0]};
    end

    always_ff @(posedge write_clk or posedge write_reset) begin
        if (write_reset) begin
            bin             <= '0;
            gray_reg        <= '0;
            full_reg        <= 1'b0;
            almost_full_reg <= 1'b0;
            level_reg       <= '0;
            overflow_reg    <= 1'b0;
        end else begin
            bin             <= bin_next;
            gray_reg        <= gray_next;
            full_reg        <= (gray_next == full_match);
            almost_full_reg <= (level_next >= almost_full_level);
            level_reg       <= level_next;
            // A refused write wins over a clear in the same cycle.
            if (bus.write_increment & full_reg) begin
                overflow_reg <= 1'b1;
            end else if (bus.write_overflow_clear) begin
                overflow_reg <= 1'b0;
            end
        end
    end

    assign bus.write_accept      = accept;
    assign bus.write_address     = bin[address_size-1:0];
    assign bus.write_pointer     = gray_reg;
    assign bus.write_full        = full_reg;
    assign bus.write_almost_full = almost_full_reg;
    assign bus.write_level       = level_reg;
    assign bus.write_overflow    = overflow_reg;
endmodule
